mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
- IEEE 802.3 clause-22 MDIO/SMI management master for the Ethernet MAC; sequences complete PHY register read/write frames from a single command handshake.
- Generates MDC (1 MHz at 100 MHz clk with default CLK_DIV) and drives/samples the tri-state MDIO pin through separate o/oe/i signals; the pad buffer sits at top level.
- Sits between the MAC management register block (command source) and the PHY pins.

Parameters:
- CLK_DIV, 50, clk cycles per MDC half-period (legal range 2..255); one MDIO bit = 2*CLK_DIV cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_phy_addr  in  5  PHYAD
- cmd_reg_addr  in  5  REGAD
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse at frame completion
- rsp_rdata  out  16  read data; held until the next read completes
- rsp_err  out  1  read TA second bit sampled 1 (no PHY responding); qualified by rsp_valid
- busy  out  1  frame in progress
- mdc  out  1  management clock
- mdio_o  out  1  MDIO output value
- mdio_oe  out  1  MDIO output enable
- mdio_i  in  1  MDIO pin input

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; mdc=0, mdio_o=1, mdio_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0. Applies mid-frame: frame abandoned, no rsp_valid.
- Acceptance: command fields latched on the accept cycle (cycle 0). cmd_valid while busy is ignored (not queued).
- Frame (64 bits, MSB first): 32x '1' preamble; ST=01; OP=01 write / 10 read; PHYAD[4:0]; REGAD[4:0]; TA; DATA[15:0].
- TA: write drives 1,0; read releases (mdio_oe=0) for TA bit 1 onward through the end of DATA.
- Timing: internal half-period counter runs only while busy. Bit n (n=0..63) is driven from cycle 1+2n*CLK_DIV; mdc=0 for the first CLK_DIV cycles of the bit and 1 for the second CLK_DIV cycles.
- Sampling: mdio_i is sampled on the cycle mdc goes 0->1 (PHY drives on falling edges).
- Completion: rsp_valid pulses at cycle 1+128*CLK_DIV. mdc=0 and mdio_oe=0 on the same cycle. cmd_ready returns high the next cycle.
- Default timing: 6401 cycles from accept to rsp_valid.
- rsp_err: write frames always 0; read frames = sampled TA bit 2.
- States: IDLE -> PREAMBLE (32 bits) -> HEADER (ST, OP, PHYAD, REGAD: 14 bits) -> TURNAROUND (2 bits) -> DATA (16 bits) -> DONE (1 cycle) -> IDLE.
- Bit counter: 6 bits, clears on every state entry.
- Idle pins: mdc=0, mdio_oe=0, mdio_o=1.
- Back-to-back: a command presented on the cycle cmd_ready re-asserts starts the next frame; the minimum gap is 1 idle cycle.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- With the macro defined: adds input port cfg_no_preamble (1 bit), sampled at command accept. When 1, the PREAMBLE state is skipped: 32-bit frame, rsp_valid at cycle 1+64*CLK_DIV.
- Without the macro: port absent; preamble always sent.

Decomposition:
- Package mdio_pkg:
  - state enum: IDLE, PREAMBLE, HEADER, TURNAROUND, DATA, DONE
  - constants: MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, PREAMBLE_BITS=32, HEADER_BITS=14, TA_BITS=2, DATA_BITS=16
- Sub-module mdio_tick_gen: parameter CLK_DIV; enable in; outputs rise_tick and fall_tick. Counter held at 0 while disabled; rise_tick fires the cycle mdc must go high.
- The FSM and shift register stay in mdio_master.

Test Plan:
- Reset, then write phy=5'h01, reg=5'h00, wdata=16'h1140 -> on MDC rising edges: 32x1, then 0101 00001 00000 10, then 0001000101000000; rsp_valid at cycle 6401; rsp_err=0.
- Read phy=5'h1F, reg=5'h02; bench PHY drives TA 0 then 16'h0141 on falling edges -> rsp_rdata=16'h0141, rsp_err=0; mdio_oe=0 from TA bit 1 to end.
- Read with mdio_i pulled high (no PHY) -> rsp_rdata=16'hFFFF, rsp_err=1.
- cmd_valid held high for two commands -> second accepted on the cycle after rsp_valid; extra cmd_valid pulses mid-frame ignored; busy continuous except the 1-cycle gap.
- reset_n low at bit 40 of a write -> next cycle mdc=0, mdio_oe=0, cmd_ready=1; no rsp_valid.
- MDIO_PREAMBLE_SUPPRESS_EN defined, cfg_no_preamble=1, CLK_DIV=2 -> 32-bit frame, rsp_valid at cycle 129.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and constants for the clause-22 MDIO management master.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PREAMBLE   = 3'd1,
        HEADER     = 3'd2,
        TURNAROUND = 3'd3,
        DATA       = 3'd4,
        DONE       = 3'd5
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam int PREAMBLE_BITS = 32;
    localparam int HEADER_BITS   = 14;
    localparam int TA_BITS       = 2;
    localparam int DATA_BITS     = 16;

    // Everything after the preamble, MSB first; read frames carry ones where the pin is released.
    function automatic logic [31:0] mdio_frame(input logic write, input logic [4:0] phyad,
                                               input logic [4:0] regad, input logic [15:0] wdata);
        return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad,
                (write ? 2'b10 : 2'b11), (write ? wdata : 16'hFFFF)};
    endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Command/response handshake between the MAC management block and the MDIO master.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mdio_tick_gen.sv
// MDC half-period strobe generator; rise_tick marks the cycle before MDC goes high.
module mdio_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic rise_tick,
    output logic fall_tick
);
    logic [7:0] cnt_r;
    logic       phase_r;
    logic       half_s;

    // End of the current MDC half-period.
    always_comb begin
        half_s = enable && (cnt_r == 8'(CLK_DIV - 1));
    end

    assign rise_tick = half_s && !phase_r;
    assign fall_tick = half_s && phase_r;

    // Half-period counter, parked at zero whenever no frame is running.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            cnt_r   <= 8'd0;
            phase_r <= 1'b0;
        end else if (half_s) begin
            cnt_r   <= 8'd0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + 8'd1;
        end
    end
endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one command handshake sequences a full read/write frame.
// Optional MDIO_PREAMBLE_SUPPRESS_EN adds cfg_no_preamble to skip the 32-bit preamble.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic         clk,
    input  logic         reset_n,
    mdio_master_if.slave bus,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic         cfg_no_preamble,
`endif
    output logic         busy,
    output logic         mdc,
    output logic         mdio_o,
    output logic         mdio_oe,
    input  logic         mdio_i
);
    mdio_state_e state_r;
    logic [5:0]  bit_cnt_r;
    logic [31:0] tx_r;
    logic [15:0] rx_r;
    logic        write_r, ta_err_r;
    logic        cmd_ready_r, busy_r, mdc_r, mdio_o_r, mdio_oe_r;
    logic        rsp_valid_r, rsp_err_r;
    logic [15:0] rsp_rdata_r;
    logic        rise_s, fall_s, accept_s, skip_pre_s;
    logic [31:0] frame_s;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign skip_pre_s = cfg_no_preamble;
`else
    assign skip_pre_s = 1'b0;
`endif

    assign accept_s = bus.cmd_valid && cmd_ready_r;
    assign frame_s  = mdio_frame(bus.cmd_write, bus.cmd_phy_addr, bus.cmd_reg_addr, bus.cmd_wdata);

    mdio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (busy_r),
        .rise_tick (rise_s),
        .fall_tick (fall_s)
    );

    // Frame sequencer: every pin change lands on an MDC tick, so all outputs are registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 6'd0;
            tx_r        <= 32'd0;
            rx_r        <= 16'd0;
            write_r     <= 1'b0;
            ta_err_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            mdc_r       <= 1'b0;
            mdio_o_r    <= 1'b1;
            mdio_oe_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 16'd0;
        end else begin
            rsp_valid_r <= 1'b0;
            if (rise_s) begin
                mdc_r <= 1'b1;
            end else if (fall_s) begin
                mdc_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        mdio_oe_r   <= 1'b1;
                        write_r     <= bus.cmd_write;
                        bit_cnt_r   <= 6'd0;
                        if (skip_pre_s) begin
                            state_r  <= HEADER;
                            mdio_o_r <= frame_s[31];
                            tx_r     <= {frame_s[30:0], 1'b1};
                        end else begin
                            state_r  <= PREAMBLE;
                            mdio_o_r <= 1'b1;
                            tx_r     <= frame_s;
                        end
                    end
                end
                PREAMBLE: begin
                    if (fall_s) begin
                        if (bit_cnt_r == 6'(PREAMBLE_BITS - 1)) begin
                            state_r   <= HEADER;
                            bit_cnt_r <= 6'd0;
                            mdio_o_r  <= tx_r[31];
                            tx_r      <= {tx_r[30:0], 1'b1};
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end
                    end
                end
                HEADER: begin
                    if (fall_s) begin
                        mdio_o_r <= tx_r[31];
                        tx_r     <= {tx_r[30:0], 1'b1};
                        if (bit_cnt_r == 6'(HEADER_BITS - 1)) begin
                            state_r   <= TURNAROUND;
                            bit_cnt_r <= 6'd0;
                            mdio_oe_r <= write_r;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end
                    end
                end
                TURNAROUND: begin
                    // A responding PHY pulls the second TA bit low; a floating bus reads 1.
                    if (rise_s && bit_cnt_r == 6'(TA_BITS - 1)) begin
                        ta_err_r <= mdio_i;
                    end
                    if (fall_s) begin
                        mdio_o_r <= tx_r[31];
                        tx_r     <= {tx_r[30:0], 1'b1};
                        if (bit_cnt_r == 6'(TA_BITS - 1)) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 6'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (rise_s) begin
                        rx_r <= {rx_r[14:0], mdio_i};
                    end
                    if (fall_s) begin
                        if (bit_cnt_r == 6'(DATA_BITS - 1)) begin
                            state_r     <= DONE;
                            bit_cnt_r   <= 6'd0;
                            mdio_oe_r   <= 1'b0;
                            mdio_o_r    <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= !write_r && ta_err_r;
                            if (!write_r) begin
                                rsp_rdata_r <= rx_r;
                            end
                        end else begin
                            mdio_o_r  <= tx_r[31];
                            tx_r      <= {tx_r[30:0], 1'b1};
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    bit_cnt_r   <= 6'd0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    bit_cnt_r   <= 6'd0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    mdc_r       <= 1'b0;
                    mdio_o_r    <= 1'b1;
                    mdio_oe_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign busy          = busy_r;
    assign mdc           = mdc_r;
    assign mdio_o        = mdio_o_r;
    assign mdio_oe       = mdio_oe_r;
endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: pin-level bit checks on MDC rises plus a response scoreboard.
module tb_mdio_master;
    import mdio_pkg::*;

    localparam int DIV       = 50;
    localparam int FRAME_LAT = 1 + 128 * DIV;

    typedef struct {logic o; logic oe; logic chk_o;} bit_t;
    typedef struct {logic [15:0] rdata; logic err;} rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy, mdc, mdio_o, mdio_oe;
    logic mdio_i = 1'b1;
    logic mdc_prev = 1'b0;
    logic phy_en = 1'b0;
    logic [15:0] phy_data = 16'h0000;
    logic [15:0] model_rdata = 16'h0000;

    bit_t bit_q[$];
    rsp_t exp_q[$];
    int   acc_q[$];
    int   n_vec = 0, n_miss = 0, n_rsp = 0, cyc = 0, rise_cnt = 0;

    mdio_master_if bus();

    mdio_master #(.CLK_DIV(DIV)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        .cfg_no_preamble (1'b0),
`endif
        .busy            (busy),
        .mdc             (mdc),
        .mdio_o          (mdio_o),
        .mdio_oe         (mdio_oe),
        .mdio_i          (mdio_i)
    );

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    mdio_master_if bus2();
    logic busy2, mdc2, mdio_o2, mdio_oe2;
    mdio_master #(.CLK_DIV(2)) dut2 (
        .clk (clk), .reset_n (reset_n), .bus (bus2), .cfg_no_preamble (1'b1),
        .busy (busy2), .mdc (mdc2), .mdio_o (mdio_o2), .mdio_oe (mdio_oe2), .mdio_i (1'b1)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pin monitor, bench PHY and response scoreboard, all sampled on the falling clock edge.
    always @(negedge clk) begin
        bit_t b;
        rsp_t r;
        int   a;
        if (reset_n && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
        if (!busy) begin
            rise_cnt = 0;
            mdio_i   = 1'b1;
        end else if (mdc && !mdc_prev) begin
            if (bit_q.size() == 0) begin
                check("bit_q_empty", 32'(bit_q.size()), 32'd1);
            end else begin
                b = bit_q.pop_front();
                check($sformatf("bit%0d_oe", rise_cnt), mdio_oe, b.oe);
                if (b.chk_o) check($sformatf("bit%0d_o", rise_cnt), mdio_o, b.o);
            end
            rise_cnt++;
        end else if (!mdc && mdc_prev) begin
            if (phy_en && rise_cnt == 47) mdio_i = 1'b0;
            else if (phy_en && rise_cnt >= 48 && rise_cnt <= 63) mdio_i = phy_data[63 - rise_cnt];
            else mdio_i = 1'b1;
        end
        mdc_prev = mdc;
        if (bus.rsp_valid === 1'b1) begin
            check("done_pins", {mdc, mdio_oe}, 2'b00);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                r = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, r.rdata);
                check("rsp_err", bus.rsp_err, r.err);
            end
            if (acc_q.size() != 0) begin
                a = acc_q.pop_front();
                check("rsp_latency", cyc - a, FRAME_LAT);
            end
            n_rsp++;
        end
    end

    // Expected pin bits and response for one command; also places it on the bus.
    task automatic issue(input logic wr, input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd);
        logic [13:0] hdr;
        hdr = {2'b01, (wr ? 2'b01 : 2'b10), phy, ra};
        for (int i = 0; i < 32; i++) bit_q.push_back('{1'b1, 1'b1, 1'b1});
        for (int i = 13; i >= 0; i--) bit_q.push_back('{hdr[i], 1'b1, 1'b1});
        if (wr) begin
            bit_q.push_back('{1'b1, 1'b1, 1'b1});
            bit_q.push_back('{1'b0, 1'b1, 1'b1});
            for (int i = 15; i >= 0; i--) bit_q.push_back('{wd[i], 1'b1, 1'b1});
            exp_q.push_back('{model_rdata, 1'b0});
        end else begin
            for (int i = 0; i < 18; i++) bit_q.push_back('{1'b1, 1'b0, 1'b0});
            model_rdata = phy_en ? phy_data : 16'hFFFF;
            exp_q.push_back('{model_rdata, !phy_en});
        end
        bus.cmd_write    = wr;
        bus.cmd_phy_addr = phy;
        bus.cmd_reg_addr = ra;
        bus.cmd_wdata    = wd;
    endtask

    task automatic send();
        @(negedge clk) bus.cmd_valid = 1'b1;
        @(posedge clk) #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int k;
        k = 0;
        while (n_rsp < target && k < 8000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("rsp_count", n_rsp, target);
    endtask

    initial begin
        int k, idle, seen, acc, acc_k, last_rsp;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_phy_addr = 5'h00;
        bus.cmd_reg_addr = 5'h00;
        bus.cmd_wdata = 16'h0000;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        bus2.cmd_valid = 1'b0;
        bus2.cmd_write = 1'b1;
        bus2.cmd_phy_addr = 5'h01;
        bus2.cmd_reg_addr = 5'h00;
        bus2.cmd_wdata = 16'h1140;
`endif
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_state", {bus.cmd_ready, busy, mdc, mdio_o, mdio_oe, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata},
              {7'b1001000, 16'h0000});

        issue(1'b1, 5'h01, 5'h00, 16'h1140);
        send();
        wait_rsp(1);

        phy_en = 1'b1;
        phy_data = 16'h0141;
        issue(1'b0, 5'h1F, 5'h02, 16'h0000);
        send();
        wait_rsp(2);

        phy_en = 1'b0;
        issue(1'b0, 5'h00, 5'h03, 16'h0000);
        send();
        wait_rsp(3);

        // Back-to-back with cmd_valid held, then stray pulses mid-frame.
        phy_en = 1'b1;
        phy_data = 16'hA5C3;
        issue(1'b1, 5'h03, 5'h04, 16'hBEEF);
        @(negedge clk) bus.cmd_valid = 1'b1;
        @(posedge clk) #1;
        issue(1'b0, 5'h03, 5'h05, 16'h0000);
        k = 0; idle = 0; seen = 0; acc = 1; acc_k = 0; last_rsp = 0;
        while (seen < 2 && k < 16000) begin
            @(negedge clk);
            k++;
            if (!busy) idle++;
            if (bus.rsp_valid) begin
                seen++;
                last_rsp = cyc;
            end
            if (acc == 2 && k == acc_k + 200) bus.cmd_valid = 1'b1;
            if (acc == 2 && k == acc_k + 260) bus.cmd_valid = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc++;
                acc_k = k;
                check("b2b_accept_gap", cyc - last_rsp, 1);
                @(posedge clk) #1 bus.cmd_valid = 1'b0;
            end
        end
        check("b2b_rsp", seen, 2);
        check("b2b_idle_cycles", idle, 1);
        check("b2b_accepts", acc, 2);
        @(negedge clk);
        check("b2b_busy_after", busy, 1'b0);

        // Reset during bit 40 of a write abandons the frame.
        phy_en = 1'b0;
        issue(1'b1, 5'h07, 5'h09, 16'h1234);
        send();
        k = 0;
        while (!(rise_cnt == 40 && mdc == 1'b0) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check("rst_reached_bit40", rise_cnt, 40);
        reset_n = 1'b0;
        @(posedge clk) #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_pins", {mdc, mdio_oe, bus.cmd_ready, busy, bus.rsp_valid}, 5'b00100);
        bit_q.delete();
        acc_q.delete();
        exp_q.delete();
        seen = 0;
        repeat (3000) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("rst_no_rsp", seen, 0);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        @(negedge clk) bus2.cmd_valid = 1'b1;
        acc = cyc;
        @(posedge clk) #1 bus2.cmd_valid = 1'b0;
        k = 0; seen = 0;
        while (bus2.rsp_valid !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
            if (mdc2 && !mdc_prev) seen = seen;
        end
        check("nopre_latency", cyc - acc, 129);
        check("nopre_err", bus2.rsp_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
